// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/redirect controller:
// AddrMUX select codes, controller state and register-index width.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int ADDR_SEL_W = 3;

    typedef logic [ADDR_SEL_W-1:0] addr_sel_t;

    localparam addr_sel_t ADDR_PC4    = 3'd0;
    localparam addr_sel_t ADDR_BRANCH = 3'd1;
    localparam addr_sel_t ADDR_JUMP   = 3'd2;
    localparam addr_sel_t ADDR_JR     = 3'd3;
    localparam addr_sel_t ADDR_EXC    = 3'd4;
    localparam addr_sel_t ADDR_EPC    = 3'd5;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/mdu_busy_ctr.sv
// Multiply/divide busy tracker: loads LAT on start, counts down to zero and holds there.
module mdu_busy_ctr #(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic busy_o
);

    localparam int CW = $clog2(LAT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A restart while busy simply reloads the full latency.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/next-PC sequencer for the 5-stage pipeline (branches resolve in ID).
// Define HAZARD_PERF_EN to add the stall and redirect cycle counters.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 4
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic                  clkIn,
    input  logic                  resetIn,
    input  logic [REG_IDX_W-1:0]  idRsIn,
    input  logic [REG_IDX_W-1:0]  idRtIn,
    input  logic                  idUsesRtIn,
    input  logic [REG_IDX_W-1:0]  exRtIn,
    input  logic                  exMemReadIn,
    input  logic                  idBranchTkIn,
    input  logic                  idJumpIn,
    input  logic                  idJrIn,
    input  logic                  idEretIn,
    input  logic                  idMduUseIn,
    input  logic                  exMduStartIn,
    input  logic                  exExcIn,
    output logic                  pcStallOut,
    output logic                  pcFlushOut,
    output logic [ADDR_SEL_W-1:0] addrSelOut,
    output logic                  ifidStallOut,
    output logic                  ifidFlushOut,
    output logic                  idexFlushOut,
    output logic                  exmemFlushOut,
    output logic                  mduBusyOut,
    output ctrl_state_e           dbgStateOut
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]      stallCntOut,
    output logic [CNT_W-1:0]      flushCntOut
`endif
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    logic mdu_busy;
    logic load_use;
    logic mdu_haz;
    logic exc_take;
    logic hold;
    logic eret_take;

    logic      pc_stall;
    logic      pc_flush;
    addr_sel_t addr_sel;
    logic      ifid_stall;
    logic      ifid_flush;
    logic      idex_flush;
    logic      exmem_flush;

    // An exception in EX squashes the MDU start issued by that same instruction.
    mdu_busy_ctr #(
        .LAT (MDU_LAT)
    ) u_mdu_busy_ctr (
        .clk    (clkIn),
        .rst_n  (resetIn),
        .load_i (exMduStartIn && !exc_take),
        .busy_o (mdu_busy)
    );

    always_comb begin
        load_use  = exMemReadIn && (exRtIn != '0) &&
                    ((exRtIn == idRsIn) || (idUsesRtIn && (exRtIn == idRtIn)));
        mdu_haz   = idMduUseIn && mdu_busy;
        exc_take  = exExcIn && (state_q == ST_RUN);
        hold      = !exc_take && (load_use || mdu_haz);
        eret_take = !exc_take && !hold && idEretIn && (state_q == ST_HANDLER);
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (exc_take) begin
            state_d = ST_HANDLER;
        end else if (eret_take) begin
            state_d = ST_RUN;
        end
    end

    // Priority chain: exception, data hazards, then ID redirects (eret > jr > jump > branch).
    always_comb begin
        pc_stall    = 1'b0;
        pc_flush    = 1'b0;
        addr_sel    = ADDR_PC4;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (exc_take) begin
            pc_flush    = 1'b1;
            addr_sel    = ADDR_EXC;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (hold) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end else if (eret_take) begin
            pc_flush   = 1'b1;
            addr_sel   = ADDR_EPC;
            ifid_flush = 1'b1;
        end else if (idJrIn) begin
            pc_flush   = 1'b1;
            addr_sel   = ADDR_JR;
            ifid_flush = 1'b1;
        end else if (idJumpIn) begin
            pc_flush   = 1'b1;
            addr_sel   = ADDR_JUMP;
            ifid_flush = 1'b1;
        end else if (idBranchTkIn) begin
            pc_flush   = 1'b1;
            addr_sel   = ADDR_BRANCH;
            ifid_flush = 1'b1;
        end
    end

    // All controls read as zero while reset is asserted.
    assign pcStallOut    = pc_stall && resetIn;
    assign pcFlushOut    = pc_flush && resetIn;
    assign addrSelOut    = resetIn ? addr_sel : ADDR_PC4;
    assign ifidStallOut  = ifid_stall && resetIn;
    assign ifidFlushOut  = ifid_flush && resetIn;
    assign idexFlushOut  = idex_flush && resetIn;
    assign exmemFlushOut = exmem_flush && resetIn;
    assign mduBusyOut    = mdu_busy && resetIn;
    assign dbgStateOut   = state_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall);
        flush_cnt_d = flush_cnt_q + CNT_W'(pc_flush);
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCntOut = stall_cnt_q;
    assign flushCntOut = flush_cnt_q;
`endif

endmodule
